// File: rtl/fifo_unpacker.sv
// Unpacks FIFO words into narrow beats; first beat the cycle after yumi_o, 1 beat/cycle.
// ready_i=0 holds the beat and counter; UNPACK_MSB_FIRST_EN selects MSB-first beat order.
module fifo_unpacker #(
    parameter int width_p  = 32,
    parameter int narrow_p = 8
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                valid_i,
    input  logic [width_p-1:0]  data_i,
    output logic                yumi_o,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [narrow_p-1:0] data_o,
    output logic                last_o
);
    localparam int ratio_lp = width_p / narrow_p;
    localparam int cnt_w_lp = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
    localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(ratio_lp - 1);

    typedef enum logic {EMPTY, BUSY} state_e;

    state_e                state_r, state_n;
    logic [cnt_w_lp-1:0]   cnt_r, cnt_n;
    logic [width_p-1:0]    word_r, word_n;
    logic [cnt_w_lp-1:0]   beat_idx;
    logic                  busy, last, fire, take;

    assign busy = (state_r == BUSY);
    assign last = busy && (cnt_r == cnt_max_lp);
    assign fire = busy && ready_i;
    // Fetch when idle, or in the same cycle the final beat leaves, so words abut.
    assign take = valid_i && (!busy || (fire && last));

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        word_n  = word_r;
        if (take) begin
            word_n  = data_i;
            cnt_n   = '0;
            state_n = BUSY;
        end else if (fire) begin
            if (last) begin
                state_n = EMPTY;
            end else begin
                cnt_n = cnt_r + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= EMPTY;
            cnt_r   <= '0;
            word_r  <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            word_r  <= word_n;
        end
    end

`ifdef UNPACK_MSB_FIRST_EN
    assign beat_idx = cnt_max_lp - cnt_r;
`else
    assign beat_idx = cnt_r;
`endif

    assign data_o  = word_r[beat_idx*narrow_p +: narrow_p];
    assign yumi_o  = reset_n_i & take;
    assign valid_o = reset_n_i & busy;
    assign last_o  = reset_n_i & last;
endmodule

// File: tb/tb_fifo_unpacker.sv
// Bench for fifo_unpacker: queue-based beat scoreboard checked every cycle plus directed literal cases.
module tb_fifo_unpacker;
    localparam int W = 32;
    localparam int N = 8;
    localparam int R = W / N;

    logic         clk = 1'b0;
    logic         reset_n_i = 1'b0;
    logic         valid_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         ready_i = 1'b0;
    logic         yumi_o, valid_o, last_o;
    logic [N-1:0] data_o;

    always #5 clk = ~clk;

    fifo_unpacker #(.width_p(W), .narrow_p(N)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .valid_i(valid_i), .data_i(data_i),
        .yumi_o(yumi_o), .ready_i(ready_i), .valid_o(valid_o), .data_o(data_o),
        .last_o(last_o)
    );

    typedef struct {logic [N-1:0] d; logic l;} beat_t;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    logic         gate = 1'b0;
    beat_t        exp_q[$];
    logic [W-1:0] src[$];
    logic [N-1:0] xfer_d[$];
    logic         xfer_l[$];
    int           xfer_c[$];
    logic [N-1:0] vis_d[$];
    int           yumi_c[$];
    int           n_valid, n_yumi_hi, n_last_hi;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [N-1:0] chunk(input logic [W-1:0] w, input int k);
        int idx;
`ifdef UNPACK_MSB_FIRST_EN
        idx = R - 1 - k;
`else
        idx = k;
`endif
        return N'(w >> (idx * N));
    endfunction

    task automatic clear_logs();
        xfer_d.delete(); xfer_l.delete(); xfer_c.delete();
        vis_d.delete(); yumi_c.delete();
        n_valid = 0; n_yumi_hi = 0; n_last_hi = 0;
    endtask

    // One cycle of stimulus, applied just after the rising edge.
    task automatic step(input logic r, input logic rn, input logic g);
        @(posedge clk);
        #1;
        cyc++;
        ready_i   = r;
        reset_n_i = rn;
        gate      = g;
        valid_i   = gate && (src.size() > 0);
        data_i    = valid_i ? src[0] : W'($urandom);
    endtask

    // Reference: outstanding beats of fetched words, fetch whenever nothing would remain.
    always @(negedge clk) begin
        logic ev, el, ey;
        ev = reset_n_i && (exp_q.size() > 0);
        el = ev && exp_q[0].l;
        ey = reset_n_i && valid_i && ((exp_q.size() == 0) || (ready_i && el));
        chk("valid_o", valid_o, ev);
        chk("yumi_o", yumi_o, ey);
        chk("last_o", last_o, el);
        if (ev) chk("data_o", data_o, exp_q[0].d);

        if (valid_o) begin
            vis_d.push_back(data_o);
            n_valid++;
        end
        if (valid_o && ready_i) begin
            xfer_d.push_back(data_o);
            xfer_l.push_back(last_o);
            xfer_c.push_back(cyc);
        end
        if (yumi_o) begin
            yumi_c.push_back(cyc);
            n_yumi_hi++;
        end
        if (last_o) n_last_hi++;

        if (!reset_n_i) begin
            exp_q.delete();
        end else begin
            if (ev && ready_i) void'(exp_q.pop_front());
            if (ey) for (int k = 0; k < R; k++) exp_q.push_back('{chunk(data_i, k), (k == R - 1)});
        end
        if (yumi_o && src.size() > 0) void'(src.pop_front());
    end

    logic [N-1:0] e1[4];
    logic [N-1:0] e2[8];
    logic [N-1:0] e4[7];
    logic [N-1:0] a;
    logic         seen;

    initial begin
`ifdef UNPACK_MSB_FIRST_EN
        e1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        e2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        e4 = '{8'hDE, 8'hDE, 8'hDE, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`else
        e1 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        e2 = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        e4 = '{8'hEF, 8'hEF, 8'hEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`endif
        clear_logs();
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("reset_valid", valid_o, 1'b0);

        // Single word, ready held high.
        clear_logs();
        src.push_back(32'hA1B2C3D4);
        repeat (8) step(1'b1, 1'b1, 1'b1);
        chk("single_nbeats", xfer_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            a = (i < xfer_d.size()) ? xfer_d[i] : 8'hxx;
            chk($sformatf("single_beat%0d", i), a, e1[i]);
            chk($sformatf("single_last%0d", i), (i < xfer_l.size()) ? xfer_l[i] : 1'bx, (i == 3));
        end
        if (xfer_c.size() == 4) chk("single_span", xfer_c[3] - xfer_c[0], 3);
        chk("single_yumis", yumi_c.size(), 1);

        // Back-to-back words with no bubble.
        clear_logs();
        src.push_back(32'h11223344);
        src.push_back(32'h55667788);
        repeat (14) step(1'b1, 1'b1, 1'b1);
        chk("b2b_nbeats", xfer_d.size(), 8);
        for (int i = 0; i < 8; i++) begin
            a = (i < xfer_d.size()) ? xfer_d[i] : 8'hxx;
            chk($sformatf("b2b_beat%0d", i), a, e2[i]);
        end
        if (xfer_c.size() == 8) chk("b2b_span", xfer_c[7] - xfer_c[0], 7);
        chk("b2b_yumis", yumi_c.size(), 2);
        if (yumi_c.size() == 2 && xfer_c.size() == 8) chk("b2b_yumi_with_beat3", yumi_c[1], xfer_c[3]);

        // Backpressure on the first beat.
        clear_logs();
        src.push_back(32'hDEADBEEF);
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            step(1'b0, 1'b1, 1'b1);
            seen = valid_o;
        end
        chk("bp_first_beat_seen", seen, 1'b1);
        repeat (2) step(1'b0, 1'b1, 1'b1);
        repeat (6) step(1'b1, 1'b1, 1'b1);
        chk("bp_nvis", vis_d.size(), 7);
        for (int i = 0; i < 7; i++) begin
            a = (i < vis_d.size()) ? vis_d[i] : 8'hxx;
            chk($sformatf("bp_vis%0d", i), a, e4[i]);
        end
        chk("bp_yumis", yumi_c.size(), 1);

        // Reset in the middle of a word.
        clear_logs();
        src.push_back(32'hCAFEF00D);
        for (int t = 0; t < 10 && xfer_d.size() < 2; t++) step(1'b1, 1'b1, 1'b1);
        chk("rst_mid_beats_before", xfer_d.size(), 2);
        reset_n_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", valid_o, 1'b0);
        chk("rst_mid_yumi", yumi_o, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        clear_logs();
        repeat (6) step(1'b1, 1'b1, 1'b1);
        chk("rst_mid_after_valid_cycles", n_valid, 0);

        // Empty source.
        clear_logs();
        repeat (25) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        chk("empty_valid_cycles", n_valid, 0);
        chk("empty_yumi_cycles", n_yumi_hi, 0);
        chk("empty_last_cycles", n_last_hi, 0);

        // Random traffic with stalls, source gaps and occasional resets.
        for (int t = 0; t < 3000; t++) begin
            if (src.size() < 3 && $urandom_range(0, 2) == 0) src.push_back(W'($urandom));
            step(($urandom_range(0, 2) != 0), ($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0));
        end
        repeat (40) step(1'b1, 1'b1, 1'b1);
        chk("drain_src_empty", src.size(), 0);
        chk("drain_model_empty", exp_q.size(), 0);
        chk("drain_valid", valid_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
